// File: rtl/ram_lsu_pkg.sv
// Shared encodings for the RAM load/store initiator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ram_lsu_pkg;

    // Access size encodings carried on req_size; 2'd3 is illegal.
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Request sequencing states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } lsu_state_e;

endpackage

// File: rtl/ram_lsu_lane.sv
// Byte-lane logic: store enables/replication, misalignment, load extract+extend.
// Latency: purely combinational.
// Backpressure: none (no handshake).
//
// Ports:
//   size, is_unsigned, addr_lo : access shape (addr_lo = byte address bits [1:0])
//   st_data                    : right-justified store data
//   ld_raw                     : raw 32-bit word read from RAM
//   wen, wdata                 : byte enables and lane-replicated store data
//   misalign                   : half on odd byte, or word not on a 4-byte boundary
//   ld_data                    : aligned, extended load result
module ram_lsu_lane
    import ram_lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] st_data,
    input  logic [31:0] ld_raw,
    output logic [3:0]  wen,
    output logic [31:0] wdata,
    output logic        misalign,
    output logic [31:0] ld_data
);

    logic [31:0] shifted;

    always_comb begin
        // Move the addressed byte/half down to bit 0 before trimming.
        shifted  = ld_raw >> {addr_lo, 3'b000};
        wen      = 4'b0000;
        wdata    = st_data;
        misalign = 1'b0;
        ld_data  = shifted;
        case (size)
            SZ_BYTE: begin
                wen     = 4'b0001 << addr_lo;
                wdata   = {4{st_data[7:0]}};
                ld_data = is_unsigned ? {24'h0, shifted[7:0]}
                                      : {{24{shifted[7]}}, shifted[7:0]};
            end
            SZ_HALF: begin
                wen      = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata    = {2{st_data[15:0]}};
                misalign = addr_lo[0];
                ld_data  = is_unsigned ? {16'h0, shifted[15:0]}
                                       : {{16{shifted[15]}}, shifted[15:0]};
            end
            SZ_WORD: begin
                wen      = 4'b1111;
                misalign = |addr_lo;
            end
            default: begin
                // Illegal size: rejected by the caller; no lanes enabled.
            end
        endcase
    end

endmodule

// File: rtl/ram_lsu_master.sv
// Load/store initiator for a synchronous byte-enabled RAM with one-cycle read.
// Latency: accept at edge N -> rsp_valid pulse in the cycle after edge N+1; one request per 3 cycles.
// Backpressure: req_ready high only when idle; response has no backpressure.
//
// Ports: req_* request handshake/payload in, rsp_* one-cycle response out,
//        mem_* RAM port (wen/addr/wdata out, registered rdata in).
// Optional: define RAM_LSU_PERF_CNT_EN to add cnt_loads/cnt_stores/cnt_errs.
module ram_lsu_master
    import ram_lsu_pkg::*;
#(
    parameter int unsigned WORDS     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
)(
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
`ifdef RAM_LSU_PERF_CNT_EN
    output logic [31:0] cnt_loads,
    output logic [31:0] cnt_stores,
    output logic [31:0] cnt_errs,
`endif
    output logic [3:0]  mem_wen,
    output logic [21:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    lsu_state_e  state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [1:0]  alo_q, alo_d;
    logic        err_q, err_d;
    logic [21:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

    // The lane block looks at the live request while idle (for the error
    // check and store replication) and at the latched request afterwards.
    logic        idle;
    logic [1:0]  lane_size;
    logic        lane_uns;
    logic [1:0]  lane_alo;
    logic [3:0]  lane_wen;
    logic [31:0] lane_wdata;
    logic        lane_misalign;
    logic [31:0] lane_ld;

    assign idle      = (state_q == IDLE);
    assign lane_size = idle ? req_size     : size_q;
    assign lane_uns  = idle ? req_unsigned : uns_q;
    assign lane_alo  = idle ? req_addr[1:0] : alo_q;

    ram_lsu_lane u_lane (
        .size        (lane_size),
        .is_unsigned (lane_uns),
        .addr_lo     (lane_alo),
        .st_data     (req_wdata),
        .ld_raw      (mem_rdata),
        .wen         (lane_wen),
        .wdata       (lane_wdata),
        .misalign    (lane_misalign),
        .ld_data     (lane_ld)
    );

    // Range check on the offset from the RAM base.
    logic [31:0] off;
    logic        req_err;
    assign off     = req_addr - BASE_ADDR;
    assign req_err = (req_size == 2'd3) | lane_misalign | (req_addr < BASE_ADDR)
                   | ({2'b00, off[31:2]} >= 32'(WORDS));

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        size_d      = size_q;
        uns_d       = uns_q;
        alo_d       = alo_q;
        err_d       = err_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    alo_d   = req_addr[1:0];
                    err_d   = req_err;
                    // Errored requests still pass through ACCESS as a plain
                    // wait cycle so both outcomes share the same latency; the
                    // RAM port is left untouched for them.
                    state_d = ACCESS;
                    if (!req_err) begin
                        mem_addr_d  = off[23:2];
                        mem_wdata_d = lane_wdata;
                    end
                end
            end
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            size_q      <= SZ_BYTE;
            uns_q       <= 1'b0;
            alo_q       <= 2'b00;
            err_q       <= 1'b0;
            mem_addr_q  <= 22'h0;
            mem_wdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            alo_q       <= alo_d;
            err_q       <= err_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Write enables decode straight from state so a reset kills them at once.
    assign mem_wen   = (state_q == ACCESS && we_q && !err_q) ? lane_wen : 4'b0000;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign req_ready = idle;
    assign rsp_valid = (state_q == RESP);
    assign rsp_err   = (state_q == RESP) && err_q;
    // RAM read data for the ACCESS address is present during RESP.
    assign rsp_rdata = (state_q == RESP && !we_q && !err_q) ? lane_ld : 32'h0;

`ifdef RAM_LSU_PERF_CNT_EN
    logic [31:0] cnt_loads_q, cnt_loads_d;
    logic [31:0] cnt_stores_q, cnt_stores_d;
    logic [31:0] cnt_errs_q, cnt_errs_d;

    always_comb begin
        cnt_loads_d  = cnt_loads_q;
        cnt_stores_d = cnt_stores_q;
        cnt_errs_d   = cnt_errs_q;
        if (state_q == RESP) begin
            if (err_q)     cnt_errs_d   = cnt_errs_q + 32'd1;
            else if (we_q) cnt_stores_d = cnt_stores_q + 32'd1;
            else           cnt_loads_d  = cnt_loads_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_loads_q  <= 32'h0;
            cnt_stores_q <= 32'h0;
            cnt_errs_q   <= 32'h0;
        end else begin
            cnt_loads_q  <= cnt_loads_d;
            cnt_stores_q <= cnt_stores_d;
            cnt_errs_q   <= cnt_errs_d;
        end
    end

    assign cnt_loads  = cnt_loads_q;
    assign cnt_stores = cnt_stores_q;
    assign cnt_errs   = cnt_errs_q;
`endif

endmodule

// File: tb/tb_ram_lsu_master.sv
// Bench for ram_lsu_master: byte-addressed memory model plus per-cycle compare.
// Latency: n/a.
// Backpressure: requester holds req_* until accepted.
module tb_ram_lsu_master;

    localparam int unsigned TB_WORDS = 256;
    localparam logic [31:0] TB_BASE  = 32'h0;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata, mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic [3:0]  mem_wen;
    logic [21:0] mem_addr;
`ifdef RAM_LSU_PERF_CNT_EN
    logic [31:0] cnt_loads, cnt_stores, cnt_errs;
    int unsigned m_loads = 0, m_stores = 0, m_errs = 0;
`endif

    ram_lsu_master #(.WORDS(TB_WORDS), .BASE_ADDR(TB_BASE)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
`ifdef RAM_LSU_PERF_CNT_EN
        .cnt_loads(cnt_loads), .cnt_stores(cnt_stores), .cnt_errs(cnt_errs),
`endif
        .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] init_word(int i);
        return (i == 1) ? 32'h8000_1234 : (32'hC0DE_0000 | 32'(i));
    endfunction

    // Bench RAM: byte-enabled write, registered read.
    logic [31:0] ram [0:255];
    logic        ram_init = 1'b0;
    always @(posedge clk) begin
        if (!ram_init) begin
            for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
            ram_init <= 1'b1;
        end else begin
            for (int b = 0; b < 4; b++)
                if (mem_wen[b]) ram[mem_addr[7:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
        mem_rdata <= ram[mem_addr[7:0]];
    end

    // Reference model: flat byte memory, requests tracked in a queue.
    logic [7:0] mdl [0:1023];
    initial for (int i = 0; i < 256; i++) begin
        logic [31:0] w;
        w = init_word(i);
        for (int b = 0; b < 4; b++) mdl[4*i + b] = w[8*b +: 8];
    end

    typedef struct {
        int          due;
        logic        we;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] a;
        logic [31:0] wd;
        logic        err;
    } item_t;
    item_t q[$];

    function automatic logic mdl_err(logic [1:0] sz, logic [31:0] a);
        if (sz == 2'd3) return 1'b1;
        if (sz == 2'd1 && (a % 2) != 0) return 1'b1;
        if (sz == 2'd2 && (a % 4) != 0) return 1'b1;
        if (a < TB_BASE) return 1'b1;
        if ((a - TB_BASE) / 4 >= TB_WORDS) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] mdl_load(logic [1:0] sz, logic uns, logic [31:0] a);
        int n = 1 << sz;
        logic [31:0] v = 32'h0;
        for (int i = 0; i < n; i++) v = v | (32'(mdl[a - TB_BASE + 32'(i)]) << (8*i));
        if (n < 4 && !uns && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        return v;
    endfunction

    function automatic logic [3:0] mdl_wen(logic [1:0] sz, logic [31:0] a);
        int n = 1 << sz;
        return 4'(((1 << n) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] mdl_wdata(logic [1:0] sz, logic [31:0] wd);
        int n = 1 << sz;
        logic [31:0] v = 32'h0;
        for (int i = 0; i < 4; i++) v[8*i +: 8] = wd[8*(i % n) +: 8];
        return v;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Per-cycle compare, sampled on the falling edge.
    item_t       it;
    logic        in_resp, in_acc;
    logic [3:0]  exp_wen;
    logic [31:0] exp_rd;
    always @(negedge clk) begin
        if (!resetn) begin
            q.delete();
`ifdef RAM_LSU_PERF_CNT_EN
            m_loads = 0; m_stores = 0; m_errs = 0;
            chk("rst_cnt_loads", cnt_loads, 0);
            chk("rst_cnt_stores", cnt_stores, 0);
            chk("rst_cnt_errs", cnt_errs, 0);
`endif
            chk("rst_req_ready", req_ready, 1);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_err", rsp_err, 0);
            chk("rst_rsp_rdata", rsp_rdata, 0);
            chk("rst_mem_wen", mem_wen, 0);
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_mem_wdata", mem_wdata, 0);
        end else begin
            in_resp = (q.size() > 0) && (q[0].due == cyc);
            in_acc  = (q.size() > 0) && (q[0].due == cyc + 1);
            chk("req_ready", req_ready, q.size() == 0);
            exp_wen = 4'b0000;
            if (in_acc && !q[0].err) begin
                chk("mem_addr", mem_addr, (q[0].a - TB_BASE) >> 2);
                if (q[0].we) begin
                    exp_wen = mdl_wen(q[0].sz, q[0].a);
                    chk("mem_wdata", mem_wdata, mdl_wdata(q[0].sz, q[0].wd));
                end
            end
            chk("mem_wen", mem_wen, exp_wen);
            chk("rsp_valid", rsp_valid, in_resp);
`ifdef RAM_LSU_PERF_CNT_EN
            chk("cnt_loads", cnt_loads, m_loads);
            chk("cnt_stores", cnt_stores, m_stores);
            chk("cnt_errs", cnt_errs, m_errs);
`endif
            if (in_resp) begin
                it = q.pop_front();
                exp_rd = (it.we || it.err) ? 32'h0 : mdl_load(it.sz, it.uns, it.a);
                chk("rsp_err", rsp_err, it.err);
                chk("rsp_rdata", rsp_rdata, exp_rd);
                if (it.we && !it.err)
                    for (int i = 0; i < (1 << it.sz); i++)
                        mdl[it.a - TB_BASE + 32'(i)] = it.wd[8*i +: 8];
`ifdef RAM_LSU_PERF_CNT_EN
                if (it.err) m_errs++;
                else if (it.we) m_stores++;
                else m_loads++;
`endif
            end
            if (req_valid && req_ready)
                q.push_back('{cyc + 2, req_we, req_size, req_unsigned, req_addr, req_wdata,
                              mdl_err(req_size, req_addr)});
        end
    end

    // Results captured by do_req.
    logic [31:0] r_rd, r_wd;
    logic        r_err;
    logic [3:0]  r_wen;
    logic [21:0] r_ma;
    int          r_lat;

    // Call at #1 after a rising edge; returns #1 after the accepting edge.
    task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd, output int acc);
        int n = 0;
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd;
        while (!req_ready && n < 10) begin @(posedge clk); #1; n++; end
        chk("accept_wait", req_ready, 1);
        @(posedge clk); #1;
        acc = cyc;
    endtask

    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd);
        int acc;
        issue(we, sz, uns, a, wd, acc);
        req_valid = 1'b0;
        r_wen = mem_wen; r_ma = mem_addr; r_wd = mem_wdata;
        r_lat = 1;
        while (!rsp_valid && r_lat < 8) begin @(posedge clk); #1; r_lat++; end
        r_rd = rsp_rdata; r_err = rsp_err;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, a1, a2, a3;
        repeat (2) @(posedge clk);
        #3 resetn = 1'b1;
        @(posedge clk); #1;

        // Byte store 0xA5 at 0x6.
        do_req(1, 2'd0, 0, 32'h6, 32'h0000_00A5);
        chk("sb_wen", r_wen, 4'b0100);
        chk("sb_addr", r_ma, 1);
        chk("sb_wdata", r_wd, 32'hA5A5_A5A5);
        chk("sb_lat", r_lat, 2);
        chk("sb_err", r_err, 0);
        chk("sb_ram", ram[1], 32'h80A5_1234);

        do_req(0, 2'd1, 0, 32'h6, 0);
        chk("lh_signed", r_rd, 32'hFFFF_80A5);
        do_req(0, 2'd1, 1, 32'h6, 0);
        chk("lh_unsigned", r_rd, 32'h0000_80A5);
        do_req(0, 2'd0, 0, 32'h5, 0);
        chk("lb_signed", r_rd, 32'h0000_0012);

        // Misaligned word load.
        do_req(0, 2'd2, 0, 32'h2, 0);
        chk("lw_mis_err", r_err, 1);
        chk("lw_mis_rdata", r_rd, 0);
        chk("lw_mis_lat", r_lat, 2);
        chk("lw_mis_wen", r_wen, 0);

        // Range edges.
        do_req(1, 2'd2, 0, 32'h400, 32'h1111_2222);
        chk("sw_oor_err", r_err, 1);
        chk("sw_oor_wen", r_wen, 0);
        do_req(1, 2'd2, 0, 32'h3FC, 32'hDEAD_BEEF);
        chk("sw_top_addr", r_ma, 255);
        chk("sw_top_wen", r_wen, 4'b1111);
        do_req(0, 2'd2, 0, 32'h3FC, 0);
        chk("lw_top", r_rd, 32'hDEAD_BEEF);

        // Other error shapes and a half store in the upper lanes.
        do_req(0, 2'd3, 0, 32'h0, 0);
        chk("size3_err", r_err, 1);
        do_req(0, 2'd1, 0, 32'h3, 0);
        chk("lh_odd_err", r_err, 1);
        do_req(1, 2'd1, 0, 32'hA, 32'h5555_BEEF);
        chk("sh_wen", r_wen, 4'b1100);
        chk("sh_wdata", r_wd, 32'hBEEF_BEEF);
        do_req(0, 2'd2, 0, 32'h8, 0);
        chk("lw_after_sh", r_rd, 32'hBEEF_0002);
        do_req(0, 2'd0, 1, 32'h3FF, 0);
        chk("lbu_top", r_rd, 32'h0000_00DE);

        // Back-to-back with req_valid held high.
        issue(0, 2'd2, 0, 32'h0, 0, a0);
        issue(1, 2'd1, 0, 32'h12, 32'h1234_CAFE, a1);
        issue(0, 2'd1, 1, 32'h12, 0, a2);
        issue(0, 2'd0, 0, 32'h13, 0, a3);
        req_valid = 1'b0;
        chk("b2b_gap1", a1 - a0, 3);
        chk("b2b_gap2", a2 - a1, 3);
        chk("b2b_gap3", a3 - a2, 3);
        repeat (4) @(posedge clk); #1;

        // Reset during the ACCESS cycle of a store.
        issue(1, 2'd2, 0, 32'h20, 32'h1122_3344, a0);
        req_valid = 1'b0;
        #2 resetn = 1'b0;
        #1;
        chk("abort_wen", mem_wen, 0);
        chk("abort_ready", req_ready, 1);
        chk("abort_rsp", rsp_valid, 0);
        @(posedge clk); @(posedge clk);
        #3 resetn = 1'b1;
        repeat (3) @(posedge clk); #1;
        chk("abort_ram", ram[8], 32'hC0DE_0008);
        chk("abort_ready_after", req_ready, 1);
        do_req(0, 2'd2, 0, 32'h20, 0);
        chk("abort_reload", r_rd, 32'hC0DE_0008);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
